// File: rtl/keypad_if.sv
// Keypad scanner signal bundle: row sense lines in, column drive and key report out.
// The scanner takes the master side, the keypad/consumer side takes the slave side.
interface keypad_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotating active-low column drive, synchronized row sense,
// press/release debouncing and a one-cycle key_valid pulse per accepted press.
module keypad_scanner #(
    parameter int SCAN_DIV     = 65536,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    keypad_if.master kp
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit FAST = (DEBOUNCE_CNT == 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic [3:0]       sync1_q, sync2_q;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       col_q, col_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;

    logic             sample_s;
    logic [3:0]       row_low_s;
    logic             any_low_s;
    logic [1:0]       lowest_s;
    logic             latched_low_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             cnt_done_s;

    function automatic logic [1:0] lowest_row(input logic [3:0] low);
        if (low[0]) begin
            return 2'd0;
        end else if (low[1]) begin
            return 2'd1;
        end else if (low[2]) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

    assign sample_s      = (div_q == DIV_LAST);
    assign row_low_s     = ~sync2_q;
    assign any_low_s     = |row_low_s;
    assign lowest_s      = lowest_row(row_low_s);
    assign latched_low_s = row_low_s[row_idx_q];
    assign cnt_inc_s     = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
    assign cnt_done_s    = (cnt_inc_s == CNT_MAX);

    assign kp.col_out   = col_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_SCAN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision, only ever taken at a sample point.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SCAN: begin
                if (sample_s && any_low_s) begin
                    state_d = FAST ? ST_HOLD : ST_DEBOUNCE;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_DEBOUNCE: begin
                if (sample_s) begin
                    if (!latched_low_s) begin
                        state_d = ST_SCAN;
                    end else if (cnt_done_s) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_DEBOUNCE;
                    end
                end else begin
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_HOLD: begin
                if (sample_s && !latched_low_s) begin
                    state_d = FAST ? ST_SCAN : ST_RELEASE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_RELEASE: begin
                if (sample_s) begin
                    if (latched_low_s) begin
                        state_d = ST_HOLD;
                    end else if (cnt_done_s) begin
                        state_d = ST_SCAN;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    // Next values of the datapath and of the registered outputs.
    always_comb begin
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        case (state_q)
            ST_SCAN: begin
                if (sample_s && any_low_s) begin
                    row_idx_d = lowest_s;
                    cnt_d     = CNT_ONE;
                    if (FAST) begin
                        key_code_d  = {lowest_s, col_idx_q};
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                    end else begin
                        key_held_d  = 1'b0;
                    end
                end else if (sample_s) begin
                    col_idx_d = col_idx_q + 2'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_DEBOUNCE: begin
                if (sample_s && latched_low_s) begin
                    cnt_d = cnt_inc_s;
                    if (cnt_done_s) begin
                        key_code_d  = {row_idx_q, col_idx_q};
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                    end else begin
                        key_held_d  = 1'b0;
                    end
                end else if (sample_s) begin
                    // Bounce: abandon this key and move on to the next column.
                    cnt_d     = {CNT_W{1'b0}};
                    col_idx_d = col_idx_q + 2'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_HOLD: begin
                if (sample_s && !latched_low_s) begin
                    cnt_d = CNT_ONE;
                    if (FAST) begin
                        key_held_d = 1'b0;
                        col_idx_d  = col_idx_q + 2'd1;
                    end else begin
                        key_held_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_RELEASE: begin
                if (sample_s && !latched_low_s) begin
                    cnt_d = cnt_inc_s;
                    if (cnt_done_s) begin
                        key_held_d = 1'b0;
                        col_idx_d  = col_idx_q + 2'd1;
                    end else begin
                        key_held_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                key_held_d = 1'b0;
            end
        endcase
        col_d = ~(4'b0001 << col_idx_d);
    end

    // Divider, row synchronizer and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q       <= {DIV_W{1'b0}};
            sync1_q     <= 4'b1111;
            sync2_q     <= 4'b1111;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            cnt_q       <= {CNT_W{1'b0}};
            col_q       <= 4'b1110;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            div_q       <= sample_s ? {DIV_W{1'b0}} : div_q + DIV_W'(1);
            sync1_q     <= kp.row_in;
            sync2_q     <= sync1_q;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a 4x4 keypad matrix model drives the rows, and a
// sample-level behavioural model predicts every output on every cycle.
module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pk = 16'h0000;
    logic [3:0]  row_drv;
    int          checks = 0;
    int          errors = 0;
    int          vcount = 0;

    keypad_if kp ();

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp.master)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key at (r,c) pulls row r low while column c is driven.
    always_comb begin
        row_drv = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pk[r*4+c] && !kp.col_out[c]) row_drv[r] = 1'b0;
    end
    assign kp.row_in = row_drv;

    // Behavioural model, evaluated on sample points in terms of run lengths.
    bit       m_ready = 1'b0;
    int       m_tick, m_col, m_row, m_lowrun, m_highrun;
    bit       m_lock, m_held, m_vpulse;
    int       m_code;
    logic [3:0] m_h1, m_h2, m_rows;

    task automatic m_accept();
        m_code    = m_row * 4 + m_col;
        m_vpulse  = 1'b1;
        m_held    = 1'b1;
        m_highrun = 0;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ready = 1'b1; m_tick = 0; m_col = 0; m_row = 0; m_lowrun = 0; m_highrun = 0;
            m_lock = 1'b0; m_held = 1'b0; m_vpulse = 1'b0; m_code = 0;
            m_h1 = 4'b1111; m_h2 = 4'b1111;
        end else begin
            m_rows   = m_h2;
            m_h2     = m_h1;
            m_h1     = kp.row_in;
            m_vpulse = 1'b0;
            if (m_tick == SCAN_DIV - 1) begin
                m_tick = 0;
                if (m_held) begin
                    if (m_rows[m_row]) begin
                        m_highrun++;
                        if (m_highrun >= DEB) begin
                            m_held = 1'b0; m_lock = 1'b0; m_col = (m_col + 1) % 4;
                        end
                    end else m_highrun = 0;
                end else if (m_lock) begin
                    if (!m_rows[m_row]) begin
                        m_lowrun++;
                        if (m_lowrun >= DEB) m_accept();
                    end else begin
                        m_lock = 1'b0; m_col = (m_col + 1) % 4;
                    end
                end else if (m_rows != 4'b1111) begin
                    for (int r = 3; r >= 0; r--) if (!m_rows[r]) m_row = r;
                    m_lock = 1'b1; m_lowrun = 1;
                    if (DEB <= 1) m_accept();
                end else m_col = (m_col + 1) % 4;
            end else m_tick++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_ready) begin
            logic [3:0] one;
            one = 4'b0001;
            check("col_out",   int'(kp.col_out),   int'(4'b1111 ^ (one << m_col)));
            check("key_code",  int'(kp.key_code),  m_code);
            check("key_valid", int'(kp.key_valid), int'(m_vpulse));
            check("key_held",  int'(kp.key_held),  int'(m_held));
        end
    end

    always @(posedge clk) if (kp.key_valid) vcount++;

    task automatic wait_col(input logic [3:0] tgt);
        int n = 0;
        while (kp.col_out == tgt && n < 200) begin @(negedge clk); n++; end
        while (kp.col_out != tgt && n < 200) begin @(negedge clk); n++; end
        if (kp.col_out != tgt) timeout("wait_col");
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!kp.key_valid && n < 200) begin @(negedge clk); n++; end
        if (!kp.key_valid) timeout("wait_valid");
    endtask

    task automatic wait_released();
        int n = 0;
        while (kp.key_held && n < 300) begin @(negedge clk); n++; end
        if (kp.key_held) timeout("wait_released");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"},   int'(kp.col_out),   int'(4'b1110));
        check({tag, "_code"},  int'(kp.key_code),  0);
        check({tag, "_valid"}, int'(kp.key_valid), 0);
        check({tag, "_held"},  int'(kp.key_held),  0);
    endtask

    initial begin
        int v0;
        int n;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        n = 0;
        while (kp.col_out == 4'b1110 && n < 50) begin @(negedge clk); n++; end
        check("first_col_change_cycles", n, SCAN_DIV);
        check("first_col_value", int'(kp.col_out), int'(4'b1101));

        v0 = vcount;
        repeat (64) @(negedge clk);
        check("idle_no_valid", vcount - v0, 0);

        // Clean press of row 2, column 2.
        v0 = vcount;
        wait_col(4'b1011);
        pk = 16'h0400;
        wait_valid();
        check("clean_code", int'(kp.key_code), 10);
        check("clean_held", int'(kp.key_held), 1);
        repeat (40) @(negedge clk);
        pk = 16'h0000;
        wait_released();
        repeat (2) @(negedge clk);
        check("clean_one_pulse", vcount - v0, 1);

        // Two low samples on row 1 / column 0, then release: no acceptance.
        v0 = vcount;
        wait_col(4'b1110);
        pk = 16'h0010;
        repeat (8) @(negedge clk);
        pk = 16'h0000;
        n = 0;
        while (kp.col_out == 4'b1110 && n < 50) begin @(negedge clk); n++; end
        check("bounce_resume_col", int'(kp.col_out), int'(4'b1101));
        check("bounce_no_valid", vcount - v0, 0);

        // Rows 0 and 3 on column 3, then a bouncy release.
        v0 = vcount;
        wait_col(4'b0111);
        pk = 16'h8008;
        wait_valid();
        check("simul_code", int'(kp.key_code), 3);
        repeat (20) @(negedge clk);
        pk = 16'h0000;
        repeat (4) @(negedge clk);
        check("simul_held_a", int'(kp.key_held), 1);
        pk = 16'h8008;
        repeat (4) @(negedge clk);
        check("simul_held_b", int'(kp.key_held), 1);
        pk = 16'h0000;
        wait_released();
        repeat (2) @(negedge clk);
        check("simul_one_pulse", vcount - v0, 1);

        // Reset while a key is held; the still-pressed key must be debounced afresh.
        wait_col(4'b1101);
        pk = 16'h2000;
        wait_valid();
        repeat (5) @(negedge clk);
        check("pre_reset_held", int'(kp.key_held), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_hold_reset");
        rst_n = 1'b1;
        v0 = vcount;
        repeat (SCAN_DIV * DEB) @(negedge clk);
        check("post_reset_no_early_valid", vcount - v0, 0);
        repeat (30) @(negedge clk);
        pk = 16'h0000;
        wait_released();

        // Long hold produces a single pulse.
        v0 = vcount;
        wait_col(4'b1011);
        pk = 16'h0040;
        wait_valid();
        repeat (200) @(negedge clk);
        pk = 16'h0000;
        wait_released();
        repeat (2) @(negedge clk);
        check("long_hold_one_pulse", vcount - v0, 1);

        // Randomized key activity, including glitches and occasional resets.
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 4))
                0: pk = 16'h0000;
                1: pk = 16'(32'd1 << $urandom_range(0, 15));
                2: pk = 16'($urandom) & 16'($urandom) & 16'($urandom);
                3: pk = pk ^ 16'(32'd1 << $urandom_range(0, 15));
                default: pk = pk;
            endcase
            if ($urandom_range(0, 24) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end
        pk = 16'h0000;
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
